fpga_cfg_loader: RTL and testbench



---
 rtl/fpga_cfg_pkg.sv | 20 ++
 rtl/cfg_byte_serializer.sv | 42 ++++
 rtl/fpga_cfg_loader.sv | 103 ++++++++++
 tb/tb_fpga_cfg_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } cfg_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Counter must be able to hold the value nbytes itself, not just nbytes-1.
  function automatic int cnt_width(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// Byte-to-bit serializer driving the fabric configuration chain MSB-first.
import fpga_cfg_pkg::*;

module cfg_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       empty,
  output logic       last,
  output logic       cfg_bit,
  output logic       cfg_shift
);

  logic [7:0] shift_reg;
  logic [3:0] bit_cnt;

  // cfg_bit/cfg_shift are registered so the fabric sees clean edges; the
  // first bit is presented in the cycle right after the byte is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 4'd0;
      cfg_bit   <= 1'b0;
      cfg_shift <= 1'b0;
    end else if (load) begin
      shift_reg <= {din[6:0], 1'b0};
      bit_cnt   <= 4'd8;
      cfg_bit   <= din[7];
      cfg_shift <= 1'b1;
    end else if (bit_cnt != 4'd0) begin
      shift_reg <= {shift_reg[6:0], 1'b0};
      bit_cnt   <= bit_cnt - 4'd1;
      cfg_shift <= (bit_cnt != 4'd1);
      cfg_bit   <= (bit_cnt != 4'd1) ? shift_reg[7] : 1'b0;
    end
  end

  assign empty = (bit_cnt == 4'd0);
  assign last  = (bit_cnt == 4'd1);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: sync hunt, MSB-first chain shifting, trailing XOR check.
import fpga_cfg_pkg::*;

module fpga_cfg_loader #(
  parameter int         CFG_BITS  = 256,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_bit,
  output logic       cfg_shift,
  output logic       cfg_done,
  output logic       busy,
  output logic       error
);

  localparam int NBYTES = CFG_BITS / 8;
  localparam int BCW    = cnt_width(NBYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES);

  cfg_state_t     state, state_nxt;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     checksum;
  logic           xfer;
  logic           start_ok;
  logic           ser_load;
  logic           ser_empty;
  logic           ser_last;

  cfg_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .din       (in_data),
    .empty     (ser_empty),
    .last      (ser_last),
    .cfg_bit   (cfg_bit),
    .cfg_shift (cfg_shift)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        start_ok = start;
        if (start) state_nxt = SYNC;
      end
      SYNC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_data == SYNC_BYTE) state_nxt = LOAD;
      end
      LOAD: begin
        // Handshake only while the serializer is empty: no overlap with shifting.
        in_ready = ser_empty;
        busy     = 1'b1;
        if (ser_last && byte_cnt == LAST_BYTE) state_nxt = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (in_data == checksum) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
    xfer     = in_valid & in_ready;
    ser_load = xfer && (state == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      checksum <= 8'h00;
      cfg_done <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        byte_cnt <= '0;
        checksum <= 8'h00;
        cfg_done <= 1'b0;
        error    <= 1'b0;
      end
      if (ser_load) begin
        byte_cnt <= byte_cnt + BCW'(1);
        checksum <= checksum ^ in_data;
      end
      if (state == CHECK && xfer) begin
        cfg_done <= (in_data == checksum);
        error    <= (in_data != checksum);
      end
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench: fixed vectors, hand sequences and random streams vs. a stream model.
module tb_fpga_cfg_loader;

  localparam int CFG_BITS = 16;
  localparam int NB       = CFG_BITS / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, cfg_bit, cfg_shift, cfg_done, busy, error;

  fpga_cfg_loader #(.CFG_BITS(CFG_BITS), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_bit(cfg_bit), .cfg_shift(cfg_shift),
    .cfg_done(cfg_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Edge monitor: collects the serial chain contents and handshake timing.
  int          cyc = 0;
  logic        clr_mon = 1'b0;
  int          shift_cnt = 0;
  int          overlap_cnt = 0;
  int          first_shift = -1;
  logic [31:0] bits_cap = '0;
  int          xfer_q[$];

  always @(posedge clk) begin
    if (clr_mon) begin
      shift_cnt   <= 0;
      overlap_cnt <= 0;
      first_shift <= -1;
      bits_cap    <= '0;
      xfer_q.delete();
    end else begin
      if (cfg_shift) begin
        shift_cnt <= shift_cnt + 1;
        bits_cap  <= {bits_cap[30:0], cfg_bit};
        if (first_shift < 0) first_shift <= cyc;
      end
      if (cfg_shift && in_ready) overlap_cnt <= overlap_cnt + 1;
      if (in_valid && in_ready) xfer_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic clear);
    start = 1'b1;
    clr_mon = clear;
    @(negedge clk);
    start = 1'b0;
    clr_mon = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference: drop bytes up to the first sync, take NB payload bytes, then the check byte.
  task automatic model(input logic [7:0] s[$], output logic [31:0] bits,
                       output logic done, output logic err);
    int i;
    logic [7:0] x;
    i = 0;
    x = 8'h00;
    bits = '0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    i++;
    for (int k = 0; k < NB; k++) begin
      bits = (bits << 8) | 32'(s[i+k]);
      x = x ^ s[i+k];
    end
    done = (s[i+NB] == x);
    err  = !done;
  endtask

  task automatic run_stream(input logic [7:0] s[$], input int gapmax);
    pulse_start(1'b1);
    foreach (s[k]) send_byte(s[k], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic check_result(input string nm, input logic [31:0] eb, input logic ed, input logic ee);
    chk({nm, "_bits"},   bits_cap, eb);
    chk({nm, "_shifts"}, 32'(shift_cnt), 32'(CFG_BITS));
    chk({nm, "_done"},   32'(cfg_done), 32'(ed));
    chk({nm, "_error"},  32'(error), 32'(ee));
    chk({nm, "_busy"},   32'(busy), 32'd0);
    chk({nm, "_overlap"}, 32'(overlap_cnt), 32'd0);
  endtask

  typedef struct {
    logic [63:0] b;     // stream, first byte in [63:56]
    int          n;
    logic [31:0] bits;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  q[$];
    logic [31:0] eb;
    logic        ed, ee;
    int          n;

    tbl[0] = '{64'hA53C81BD_00000000, 4, 32'h3C81, 1'b1, 1'b0};
    tbl[1] = '{64'hA53C8100_00000000, 4, 32'h3C81, 1'b0, 1'b1};
    tbl[2] = '{64'h00FF5AA5_3C81BD00, 7, 32'h3C81, 1'b1, 1'b0};
    tbl[3] = '{64'hA5FFFF00_00000000, 4, 32'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{64'hA5A5A500_00000000, 4, 32'hA5A5, 1'b1, 1'b0};
    tbl[5] = '{64'hA5000001_00000000, 4, 32'h0000, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, in_ready, cfg_bit, cfg_shift, cfg_done, busy, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {26'd0, in_ready, cfg_bit, cfg_shift, cfg_done, busy, error}, 32'd0);

    // Fixed vectors
    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].b[63-8*k -: 8]);
      run_stream(q, (i == 0) ? 0 : i % 3);
      check_result($sformatf("vec%0d", i), tbl[i].bits, tbl[i].done, tbl[i].err);
      if (i == 0) begin
        chk("sync_to_load_xfer", 32'(xfer_q[1] - xfer_q[0]), 32'd1);
        chk("byte_period",       32'(xfer_q[2] - xfer_q[1]), 32'd9);
        chk("first_shift_lat",   32'(first_shift - xfer_q[1]), 32'd1);
        chk("check_period",      32'(xfer_q[3] - xfer_q[2]), 32'd9);
      end
    end

    // Start after an error clears it and enters SYNC; in_valid low stalls SYNC
    pulse_start(1'b1);
    chk("restart_error", 32'(error), 32'd0);
    chk("restart_busy",  32'(busy), 32'd1);
    chk("restart_ready", 32'(in_ready), 32'd1);
    repeat (10) @(negedge clk);
    chk("stall_busy",   32'(busy), 32'd1);
    chk("stall_shifts", 32'(shift_cnt), 32'd0);
    send_byte(8'hA5, 0); send_byte(8'h12, 2); send_byte(8'h34, 0); send_byte(8'h26, 3);
    check_result("after_err", 32'h1234, 1'b1, 1'b0);

    // Start in DONE drops cfg_done on the next cycle
    pulse_start(1'b1);
    chk("done_restart_done", 32'(cfg_done), 32'd0);
    chk("done_restart_busy", 32'(busy), 32'd1);

    // Start pulsed during LOAD is ignored
    send_byte(8'hA5, 0); send_byte(8'h3C, 0);
    @(negedge clk); @(negedge clk);
    pulse_start(1'b0);
    chk("busy_start_busy", 32'(busy), 32'd1);
    send_byte(8'h81, 0); send_byte(8'hBD, 0);
    check_result("busy_start", 32'h3C81, 1'b1, 1'b0);

    // Reset after 5 shift pulses
    pulse_start(1'b1);
    send_byte(8'hA5, 0); send_byte(8'h3C, 0);
    n = 0;
    while (shift_cnt < 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached", 32'(shift_cnt), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {26'd0, in_ready, cfg_bit, cfg_shift, cfg_done, busy, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h3C); q.push_back(8'h81); q.push_back(8'hBD);
    run_stream(q, 2);
    check_result("reload", 32'h3C81, 1'b1, 1'b0);

    // Random streams vs model
    for (int r = 0; r < 25; r++) begin
      logic [7:0] x, v;
      q.delete();
      x = 8'h00;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        v = 8'($urandom_range(0, 255));
        q.push_back((v == 8'hA5) ? 8'h5A : v);
      end
      q.push_back(8'hA5);
      for (int j = 0; j < NB; j++) begin
        v = 8'($urandom_range(0, 255));
        q.push_back(v);
        x = x ^ v;
      end
      if ($urandom_range(0, 1) == 1) q.push_back(x);
      else q.push_back(x ^ 8'($urandom_range(1, 255)));
      model(q, eb, ed, ee);
      run_stream(q, 3);
      check_result($sformatf("rnd%0d", r), eb, ed, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
